// File: rtl/matriz_pkg.sv
// rtl/matriz_pkg.sv - shared sizes, types and helpers for the 5x7 matrix scan driver
package matriz_pkg;

    localparam int N_ROWS  = 7;
    localparam int N_COLS  = 5;
    localparam int FRAME_W = N_ROWS * N_COLS;

    localparam logic [N_COLS-1:0] COL_OFF = 5'b11111;

    typedef logic [2:0] row_idx_t;

    function automatic logic [N_ROWS-1:0] row_onehot(input row_idx_t r);
        return 7'(1) << r;
    endfunction

    // Row 0 sits in the low bits of the frame; bit 4 of each slice is the leftmost column.
    function automatic logic [N_COLS-1:0] row_slice(input logic [FRAME_W-1:0] f, input row_idx_t r);
        return f[N_COLS*int'(r) +: N_COLS];
    endfunction

endpackage

// File: rtl/divisor_frequencia.sv
// rtl/divisor_frequencia.sv - prescaler producing a one-cycle tick every DIV clocks
module divisor_frequencia #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/varredura_matriz_5x7.sv
// rtl/varredura_matriz_5x7.sv - double-buffered row scan for the 5x7 LED matrix (option: ROW_BLANK_EN)
module varredura_matriz_5x7
    import matriz_pkg::*;
#(
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [N_ROWS-1:0]  row_sel,
    output logic [N_COLS-1:0]  col_n,
    output logic               frame_start
);

    logic               tick;
    row_idx_t           row;
    row_idx_t           row_next;
    logic               wrap;
    logic               swap;
    logic [FRAME_W-1:0] active;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] active_next;
    logic               pending;
    logic [N_ROWS-1:0]  row_drv;
    logic [N_COLS-1:0]  col_drv;

    divisor_frequencia #(
        .DIV (DIV)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign wrap        = tick && (row == row_idx_t'(N_ROWS - 1));
    assign swap        = wrap && pending;
    assign row_next    = wrap ? '0 : row + 3'd1;
    assign active_next = swap ? shadow : active;
    assign frame_ready = !pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            row         <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            row_drv     <= row_onehot('0);
            col_drv     <= COL_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (tick) begin
                row     <= row_next;
                row_drv <= row_onehot(row_next);
                col_drv <= ~row_slice(active_next, row_next);
            end
            // Swap and accept are exclusive: a swap needs pending, which holds ready low.
            if (swap) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (frame_valid && !pending) begin
                shadow  <= frame_in;
                pending <= 1'b1;
            end
        end
    end

`ifdef ROW_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    logic [BW-1:0] blank_cnt;
    logic          blanking;

    assign blanking = (blank_cnt != '0);

    // Counts down the dark cycles at the head of each slot; the post-reset slot is not blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_cnt <= '0;
        end else if (tick) begin
            blank_cnt <= BW'(BLANK_CYCLES);
        end else if (blanking) begin
            blank_cnt <= blank_cnt - BW'(1);
        end
    end

    assign row_sel = blanking ? '0 : row_drv;
    assign col_n   = blanking ? COL_OFF : col_drv;
`else
    assign row_sel = row_drv;
    assign col_n   = col_drv;
`endif

endmodule

// File: tb/tb_varredura_matriz_5x7.sv
// tb/tb_varredura_matriz_5x7.sv - self-checking bench for varredura_matriz_5x7
module tb_varredura_matriz_5x7;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int SCAN  = 7 * DIV;

    localparam logic [34:0] FA = {{6{5'b01110}}, 5'b10001};
    localparam logic [34:0] FB = {5'b00111, 5'b11000, 5'b10101, 5'b01010, 5'b11111, 5'b00000, 5'b11011};
    localparam logic [34:0] FC = {35{1'b1}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [34:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [6:0]  row_sel;
    logic [4:0]  col_n;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    varredura_matriz_5x7 #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_n       (col_n),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Model: t = clock edges since reset; slot = t/DIV, row = slot mod 7, scan boundary every 7*DIV.
    int          t = 0;
    logic [34:0] m_active = '0;
    logic [34:0] m_shadow = '0;
    logic        m_pending = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            t         <= 0;
            m_active  <= '0;
            m_shadow  <= '0;
            m_pending <= 1'b0;
            m_valid   <= 1'b1;
        end else if (m_valid) begin
            t <= t + 1;
            if (((t + 1) % SCAN == 0) && m_pending) begin
                m_active  <= m_shadow;
                m_pending <= 1'b0;
            end else if (frame_valid && !m_pending) begin
                m_shadow  <= frame_in;
                m_pending <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int         r;
        logic [6:0] exp_row;
        logic [4:0] exp_col;
        if (m_valid) begin
            r       = (t / DIV) % 7;
            exp_row = 7'(1) << r;
            exp_col = ~m_active[5*r +: 5];
`ifdef ROW_BLANK_EN
            if (t >= DIV && (t % DIV) < BLANK) begin
                exp_row = '0;
                exp_col = 5'b11111;
            end
`endif
            check("model_row_sel", 32'(row_sel), 32'(exp_row));
            check("model_col_n", 32'(col_n), 32'(exp_col));
            check("model_frame_ready", 32'(frame_ready), 32'(!m_pending));
            check("model_frame_start", 32'(frame_start), 32'(t > 0 && (t % SCAN) == 0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("reset_row_sel", 32'(row_sel), 32'(7'b0000001));
        check("reset_col_n", 32'(col_n), 32'(5'b11111));
        check("reset_ready", 32'(frame_ready), 32'(1'b1));
        check("reset_frame_start", 32'(frame_start), 32'(1'b0));

        step(5);
        check("row1_after_slot", 32'(row_sel), 32'(7'b0000010));

        step(23);
        check("wrap_frame_start", 32'(frame_start), 32'(1'b1));
        frame_valid = 1'b1;
        frame_in    = FA;

        step(1);
        check("wrap_row0", 32'(row_sel), 32'(7'b0000001));
        check("a_pending_ready", 32'(frame_ready), 32'(1'b0));
        frame_in = FB;

        step(28);
        check("a_row0_col", 32'(col_n), 32'(5'b01110));
        check("a_row0_sel", 32'(row_sel), 32'(7'b0000001));
        check("b_accepted_ready", 32'(frame_ready), 32'(1'b0));
        frame_valid = 1'b0;
        frame_in    = '0;

        step(4);
        check("a_row1_col", 32'(col_n), 32'(5'b10001));
        check("a_row1_sel", 32'(row_sel), 32'(7'b0000010));

        step(24);
        check("b_row0_col", 32'(col_n), 32'(5'b00100));
        check("b_swapped_ready", 32'(frame_ready), 32'(1'b1));

        step(84);
        check("b_repeat_row0_col", 32'(col_n), 32'(5'b00100));
        check("b_repeat_row0_sel", 32'(row_sel), 32'(7'b0000001));

        frame_valid = 1'b1;
        frame_in    = FC;
        step(1);
        check("c_pending_ready", 32'(frame_ready), 32'(1'b0));
        frame_valid = 1'b0;
        frame_in    = '0;

        step(11);
        check("row3_before_reset", 32'(row_sel), 32'(7'b0001000));

        reset = 1'b1;
        step(1);
        check("midreset_row_sel", 32'(row_sel), 32'(7'b0000001));
        check("midreset_col_n", 32'(col_n), 32'(5'b11111));
        check("midreset_ready", 32'(frame_ready), 32'(1'b1));
        check("midreset_frame_start", 32'(frame_start), 32'(1'b0));
        reset = 1'b0;

        step(29);
        check("blank_after_reset_col", 32'(col_n), 32'(5'b11111));
        check("blank_after_reset_sel", 32'(row_sel), 32'(7'b0000001));
        check("blank_after_reset_ready", 32'(frame_ready), 32'(1'b1));

        step(30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
